// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus for serial_adder.
// The controller side uses the master modport; the adder uses the slave modport.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that consumes BITS_PER_CYCLE operand bits per clock,
// LSB first, through a short ripple chain and a registered inter-chunk carry.
// Optional subtract mode is compiled in when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BITS_PER_CYCLE-1:0] chunk_sum;
    logic                      chunk_cout;
    logic                      chunk_cmsb;

`ifndef SERIAL_ADDER_SUB_EN
    // sub has no function in add-only builds
    logic unused_sub;
    assign unused_sub = bus.sub;
`endif

    // Ripple chain over the low chunk; chunk_cmsb is the carry into the chunk's top cell,
    // which on the final chunk is the carry into the result MSB.
    always_comb begin
        logic c;
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        c          = carry_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            chunk_cmsb   = c;
            chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        chunk_cout = c;
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b computed as a + ~b + 1
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            StRun: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                acc_d   = acc_q >> BITS_PER_CYCLE;
                acc_d[WIDTH-1 -: BITS_PER_CYCLE] = chunk_sum;
                carry_d = chunk_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    sum_d   = acc_d;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_cmsb;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifters, working sum, carry, chunk counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built from a chain of `BITS_PER_CYCLE` full-adder cells. It consumes `BITS_PER_CYCLE` operand bits per clock, LSB first, and carries between chunks through a registered carry. It replaces the single-cycle combinational full adder wherever area matters more than latency. It sits behind a start/busy/done handshake so a controller can launch one addition and collect a registered `sum`, `cout` and signed `ovf`.

## Interface
- `WIDTH`, default 8: operand and result width; legal when ≥ 2.
- `BITS_PER_CYCLE`, default 1: bits processed per RUN cycle; legal when ≥ 1 and it divides `WIDTH` exactly.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock, asynchronous and active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepted start.
- `b`  in  WIDTH  operand B; captured on the accepted start.
- `cin`  in  1  carry-in; captured on the accepted start.
- `sub`  in  1  subtract select; captured on the accepted start; effective only with `SERIAL_ADDER_SUB_EN`.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result.
- `cout`  out  1  carry out of the MSB.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Define N = `WIDTH`/`BITS_PER_CYCLE`.
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1.
  - Capture `a`, `b`, `cin` and `sub` into internal shift registers.
  - Chunk counter set to 0.
- RUN:
  - Each cycle, add the low `BITS_PER_CYCLE` bits of A and B plus the carry register through the full-adder chain.
  - Shift A and B right by `BITS_PER_CYCLE`.
  - Shift the partial sum in from the MSB end of a working register.
  - Update the carry register.
  - Record the carry into the MSB on the final chunk.
  - Increment the counter.
- RUN → DONE after the N-th chunk.
  - On that edge, load `sum`, `cout` and `ovf` from the working state.
  - Output registers never show partial results.
- DONE → IDLE unconditionally after one cycle. `done`=1 only in DONE.
- `start` in RUN or DONE is ignored. It is not queued, and input changes have no effect.
- `sum`, `cout` and `ovf` hold their value until the next DONE load, including across later IDLE periods.
- Add mode result: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; internal registers 0.
- Start accepted at edge E:
  - `busy`=1 from E through E+N+1, when DONE exits.
  - `done`=1 during the cycle after edge E+N.
  - `busy` falls at E+N+1.
- Latency from start edge to `done` is N cycles. Minimum start-to-start spacing is N+2 cycles.
- `start` held high continuously launches a new operation at every IDLE cycle.
- Reset asserted mid-RUN or in DONE:
  - Immediately returns to IDLE with all outputs cleared.
  - No `done` pulse for the aborted operation.
- Carry chain depth per cycle is `BITS_PER_CYCLE` full-adder cells, fed by registers.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - With `sub`=1 captured, B is inverted and the initial carry is forced to 1; `cin` is ignored. Result: sum = a − b.
  - `cout`=1 means no borrow; `ovf` uses the same signed rule.
  - With `sub`=0, add mode as above.
- Not defined: `sub` is unconnected internally and the block always adds. No subtract logic is synthesised.

## Test plan
- `WIDTH`=8, `BITS_PER_CYCLE`=2, a=8'hFF, b=8'h01, cin=0 → `done` 4 cycles after start edge; sum=8'h00, cout=1, ovf=0; `busy` high 5 cycles.
- Same config, a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1; outputs held after `done` drops.
- `SERIAL_ADDER_SUB_EN` defined, a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0, ovf=0. Macro undefined, same stimulus with cin=0 → sum=8'h0C, cout=0.
- Pulse `start` with new operands during RUN → ignored; original result delivered, exactly one `done` pulse.
- Assert `rst` on 2nd RUN cycle → `busy`=0, sum=8'h00 immediately; no `done` within N+2 cycles; next start completes normally.
- `WIDTH`=8, `BITS_PER_CYCLE`=1, a=8'hAA, b=8'h55, cin=1 → `done` 8 cycles after start edge; sum=8'h00, cout=1, ovf=0.
